// File: rtl/block_xfer_seq_if.sv
// rtl/block_xfer_seq_if.sv - memory and shared ALU bus for block_xfer_seq
// Purpose: groups the byte read/write request-acknowledge channels and the
//          connection to the shared combinational 16-bit ALU.
// Signals:
//   mem_rd_req/mem_rd_addr -> read request, held until mem_rd_ack
//   mem_rd_ack/mem_rd_data <- read acknowledge with the byte
//   mem_wr_req/mem_wr_addr/mem_wr_data -> write request, held until mem_wr_ack
//   mem_wr_ack             <- write acknowledge
//   alu16_arg1/alu16_op/alu16_flags_in -> ALU operands
//   alu16_out/alu16_flags_out          <- ALU results (combinational)
// Modports: master = sequencer side, slave = memory/ALU side.

interface block_xfer_seq_if;
    logic        mem_rd_req;
    logic [15:0] mem_rd_addr;
    logic        mem_rd_ack;
    logic [7:0]  mem_rd_data;
    logic        mem_wr_req;
    logic [15:0] mem_wr_addr;
    logic [7:0]  mem_wr_data;
    logic        mem_wr_ack;
    logic [15:0] alu16_arg1;
    logic [2:0]  alu16_op;
    logic [7:0]  alu16_flags_in;
    logic [15:0] alu16_out;
    logic [7:0]  alu16_flags_out;

    modport master (
        output mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
        output alu16_arg1, alu16_op, alu16_flags_in,
        input  mem_rd_ack, mem_rd_data, mem_wr_ack, alu16_out, alu16_flags_out
    );

    modport slave (
        input  mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
        input  alu16_arg1, alu16_op, alu16_flags_in,
        output mem_rd_ack, mem_rd_data, mem_wr_ack, alu16_out, alu16_flags_out
    );
endinterface

// File: rtl/block_xfer_seq.sv
// rtl/block_xfer_seq.sv - Z80-style LDI/LDD/LDIR/LDDR block transfer sequencer
// Purpose: copies bytes from (HL) to (DE), stepping HL/DE up or down and
//          decrementing BC through the shared 16-bit ALU, optionally repeating
//          until BC reaches zero.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start, dir, rpt       - begin (IDLE only), 0=increment/1=decrement, repeat
//   hl_in/de_in/bc_in     - initial register values, flags_in - initial F
//   hl_out/de_out/bc_out  - working registers, flags_out - working F
//   busy, done            - busy outside IDLE, done is a one-cycle pulse
//   abort, aborted        - only with BLKXFER_ABORT_EN defined
//   bus                   - block_xfer_seq_if.master (memory + ALU)
// Parameter IDLE_BC_ZERO_WRAP: 1 = BC=0 runs 65536 iterations, 0 = BC=0 ends
//   immediately without transfer.
// Optional macro: BLKXFER_ABORT_EN adds the abort input / aborted output.

module block_xfer_seq #(
    parameter bit IDLE_BC_ZERO_WRAP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dir,
    input  logic        rpt,
    input  logic [15:0] hl_in,
    input  logic [15:0] de_in,
    input  logic [15:0] bc_in,
    input  logic [7:0]  flags_in,
    output logic [15:0] hl_out,
    output logic [15:0] de_out,
    output logic [15:0] bc_out,
    output logic [7:0]  flags_out,
    output logic        busy,
    output logic        done,
`ifdef BLKXFER_ABORT_EN
    input  logic        abort,
    output logic        aborted,
`endif
    block_xfer_seq_if.master bus
);

    localparam logic [2:0] VAL_ALU16_OP_INC    = 3'd0;
    localparam logic [2:0] VAL_ALU16_OP_DEC    = 3'd1;
    localparam logic [2:0] VAL_ALU16_OP_DEC_LD = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_UPD_HL, S_UPD_DE, S_UPD_BC, S_CHK, S_DONE
    } state_t;

    state_t      state_q;
    logic [15:0] hl_q, de_q, bc_q;
    logic [7:0]  flags_q;
    logic        dir_q, rpt_q, busy_q, done_q;
    logic        rd_req_q, wr_req_q;
    logic [15:0] rd_addr_q, wr_addr_q;
    logic [7:0]  wr_data_q;          // byte latched from the read
    logic [15:0] alu_arg_q;
    logic [2:0]  alu_op_q;
    logic [7:0]  alu_flags_q;
    logic        more_iter;

`ifdef BLKXFER_ABORT_EN
    logic        aborted_q;
    assign more_iter = rpt_q && (bc_q != 16'h0000) && !abort;
    assign aborted   = aborted_q;
`else
    assign more_iter = rpt_q && (bc_q != 16'h0000);
`endif

    // All outputs come from registers. The ALU operands are loaded one state
    // ahead so they are already valid during the UPD_* state whose closing
    // edge captures the ALU result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hl_q        <= 16'h0000;
            de_q        <= 16'h0000;
            bc_q        <= 16'h0000;
            flags_q     <= 8'h00;
            dir_q       <= 1'b0;
            rpt_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            rd_addr_q   <= 16'h0000;
            wr_addr_q   <= 16'h0000;
            wr_data_q   <= 8'h00;
            alu_arg_q   <= 16'h0000;
            alu_op_q    <= VAL_ALU16_OP_INC;
            alu_flags_q <= 8'h00;
`ifdef BLKXFER_ABORT_EN
            aborted_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dir_q  <= dir;
                        rpt_q  <= rpt;
                        busy_q <= 1'b1;
`ifdef BLKXFER_ABORT_EN
                        aborted_q <= 1'b0;
`endif
                        if (!IDLE_BC_ZERO_WRAP && (bc_in == 16'h0000)) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            hl_q      <= hl_in;
                            de_q      <= de_in;
                            bc_q      <= bc_in;
                            flags_q   <= flags_in;
                            rd_req_q  <= 1'b1;
                            rd_addr_q <= hl_in;
                            state_q   <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (bus.mem_rd_ack) begin
                        rd_req_q  <= 1'b0;
                        wr_req_q  <= 1'b1;
                        wr_addr_q <= de_q;
                        wr_data_q <= bus.mem_rd_data;
                        state_q   <= S_WR;
                    end
                end
                S_WR: begin
                    if (bus.mem_wr_ack) begin
                        wr_req_q  <= 1'b0;
                        alu_arg_q <= hl_q;
                        alu_op_q  <= dir_q ? VAL_ALU16_OP_DEC : VAL_ALU16_OP_INC;
                        state_q   <= S_UPD_HL;
                    end
                end
                S_UPD_HL: begin
                    hl_q      <= bus.alu16_out;
                    alu_arg_q <= de_q;
                    state_q   <= S_UPD_DE;
                end
                S_UPD_DE: begin
                    de_q        <= bus.alu16_out;
                    alu_arg_q   <= bc_q;
                    alu_op_q    <= VAL_ALU16_OP_DEC_LD;
                    alu_flags_q <= flags_q;
                    state_q     <= S_UPD_BC;
                end
                S_UPD_BC: begin
                    bc_q        <= bus.alu16_out;
                    flags_q     <= bus.alu16_flags_out;
                    alu_arg_q   <= 16'h0000;
                    alu_op_q    <= VAL_ALU16_OP_INC;
                    alu_flags_q <= 8'h00;
                    state_q     <= S_CHK;
                end
                S_CHK: begin
                    if (more_iter) begin
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= hl_q;
                        state_q   <= S_RD;
                    end else begin
                        done_q  <= 1'b1;
`ifdef BLKXFER_ABORT_EN
                        aborted_q <= abort;
`endif
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hl_out             = hl_q;
    assign de_out             = de_q;
    assign bc_out             = bc_q;
    assign flags_out          = flags_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign bus.mem_rd_req     = rd_req_q;
    assign bus.mem_rd_addr    = rd_addr_q;
    assign bus.mem_wr_req     = wr_req_q;
    assign bus.mem_wr_addr    = wr_addr_q;
    assign bus.mem_wr_data    = wr_data_q;
    assign bus.alu16_arg1     = alu_arg_q;
    assign bus.alu16_op       = alu_op_q;
    assign bus.alu16_flags_in = alu_flags_q;

endmodule
